// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration bitstream loader.
// Optional CRC checking is enabled by defining CONFIG_LOADER_CRC_EN.
package config_loader_pkg;

    // Host interface byte width.
    localparam int WORD_W = 8;

    // Width of the bit index inside one latched byte.
    localparam int IDX_W = $clog2(WORD_W);

    // CRC-8 used to protect the bitstream (MSB-first, non-reflected).
    localparam logic [WORD_W-1:0] CRC_POLY = 8'h07;
    localparam logic [WORD_W-1:0] CRC_INIT = 8'h00;

    // Loader control states. CHECK is only reachable when CRC checking is built in.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/config_loader_crc8.sv
// Combinational CRC-8 byte update: returns the CRC after folding one more
// byte, processed MSB first. Used only when CONFIG_LOADER_CRC_EN is defined.
module config_loader_crc8
    import config_loader_pkg::*;
(
    input  logic [WORD_W-1:0] i_crc,
    input  logic [WORD_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_crc
);

    logic [WORD_W-1:0] w_acc;

    // Eight polynomial-division steps unrolled into a single combinational cone.
    always_comb begin
        w_acc = i_crc ^ i_byte;
        for (int i = 0; i < WORD_W; i++) begin
            if (w_acc[WORD_W-1]) begin
                w_acc = {w_acc[WORD_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                w_acc = {w_acc[WORD_W-2:0], 1'b0};
            end
        end
        o_crc = w_acc;
    end

endmodule

// File: rtl/config_loader.sv
// Configuration loader: accepts a bitstream byte-by-byte from a host and
// serialises exactly CHAIN_LEN bits (LSB first per byte) into the fabric
// configuration chain, then enables the fabric.
// Build option: CONFIG_LOADER_CRC_EN adds a trailing CRC-8 byte check; a
// mismatch raises error and keeps fabric_enable low.
// CHAIN_LEN legal range is 1..4096.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 17
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_data,
    output logic              cfg_shift,
    output logic              fabric_enable,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Counter wide enough to hold CHAIN_LEN itself; it stops there, never wraps.
    localparam int                CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [WORD_W-1:0]   r_byte;

    logic                w_start_ok;
    logic                w_fetch_hs;
    logic                w_last_bit;
    logic                w_byte_end;
    logic                w_error;

    // start is honoured only when no load is running.
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_fetch_hs = (r_state == FETCH) && in_valid;
    assign w_last_bit = (r_bit_cnt == LAST_BIT);
    assign w_byte_end = (r_bit_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clock or negedge nreset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and Moore outputs derived from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        w_state_nxt   = r_state;
        in_ready      = 1'b0;
        cfg_shift     = 1'b0;
        cfg_data      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        fabric_enable = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = FETCH;
                end
            end

            FETCH: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                busy      = 1'b1;
                cfg_shift = 1'b1;
                cfg_data  = r_byte[r_bit_idx];
                // Chain completion wins over byte completion; leftover bits are dropped.
                if (w_last_bit) begin
`ifdef CONFIG_LOADER_CRC_EN
                    w_state_nxt = CHECK;
`else
                    w_state_nxt = DONE;
`endif
                end else if (w_byte_end) begin
                    w_state_nxt = FETCH;
                end
            end

`ifdef CONFIG_LOADER_CRC_EN
            CHECK: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = DONE;
                end
            end
`endif

            DONE: begin
                done          = 1'b1;
                fabric_enable = ~w_error;
                if (start) begin
                    w_state_nxt = FETCH;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Byte latch and bit counters for the serialiser.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_byte    <= '0;
        end else begin
            if (w_start_ok) begin
                r_bit_cnt <= '0;
                r_bit_idx <= '0;
            end else if (w_fetch_hs) begin
                r_byte    <= in_data;
                r_bit_idx <= '0;
            end else if (r_state == SHIFT) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    logic [WORD_W-1:0] r_crc;
    logic [WORD_W-1:0] w_crc_nxt;
    logic              r_error;

    config_loader_crc8 u_crc8 (
        .i_crc  (r_crc),
        .i_byte (in_data),
        .o_crc  (w_crc_nxt)
    );

    // Running CRC over every accepted data byte, then compare against the trailer.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_crc   <= CRC_INIT;
            r_error <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_crc   <= CRC_INIT;
                r_error <= 1'b0;
            end else if (w_fetch_hs) begin
                r_crc <= w_crc_nxt;
            end else if ((r_state == CHECK) && in_valid) begin
                r_error <= (in_data != r_crc);
            end
        end
    end

    assign w_error = r_error;
`else
    assign w_error = 1'b0;
`endif

    assign error = w_error;

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader. Two instances (CHAIN_LEN 17 and 16)
// share stimulus; one is selected for observation at a time.
// Honours CONFIG_LOADER_CRC_EN to append and check the CRC trailer byte.
`timescale 1ns/1ps
module tb_config_loader;

    logic       clock = 1'b0;
    logic       nreset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       sel16;

    logic rdy_a, dat_a, sh_a, fab_a, busy_a, done_a, err_a;
    logic rdy_b, dat_b, sh_b, fab_b, busy_b, done_b, err_b;

    always #5 clock = ~clock;

    config_loader #(.CHAIN_LEN(17)) u_dut17 (
        .clock(clock), .nreset(nreset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy_a), .cfg_data(dat_a), .cfg_shift(sh_a),
        .fabric_enable(fab_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    config_loader #(.CHAIN_LEN(16)) u_dut16 (
        .clock(clock), .nreset(nreset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy_b), .cfg_data(dat_b), .cfg_shift(sh_b),
        .fabric_enable(fab_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    logic in_ready, cfg_data, cfg_shift, fabric_enable, busy, done, error;
    assign in_ready      = sel16 ? rdy_b  : rdy_a;
    assign cfg_data      = sel16 ? dat_b  : dat_a;
    assign cfg_shift     = sel16 ? sh_b   : sh_a;
    assign fabric_enable = sel16 ? fab_b  : fab_a;
    assign busy          = sel16 ? busy_b : busy_a;
    assign done          = sel16 ? done_b : done_a;
    assign error         = sel16 ? err_b  : err_a;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    bit   bits_q[$];
    int   n_hs, n_done_rise, n_illegal;
    logic prev_done = 1'b0;

    always @(negedge clock) begin
        if (nreset) begin
            if (cfg_shift) bits_q.push_back(cfg_data);
            if (in_ready && in_valid) n_hs++;
            if ((cfg_shift && in_ready) || (busy && fabric_enable) || (cfg_shift && !busy)) n_illegal++;
            if (done && !prev_done) n_done_rise++;
            prev_done = done;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] tx_q[$];

    // Chain bit i is bit (i mod 8) of byte (i div 8).
    function automatic bit model_bit(input int i);
        logic [7:0] b;
        b = tx_q[i / 8];
        return b[i % 8];
    endfunction

    // Serial-LFSR CRC-8 (x^8+x^2+x+1) over the first n bytes, MSB first.
    function automatic logic [7:0] model_crc(input int n);
        logic [7:0] c;
        logic [7:0] b;
        logic       fb;
        c = 8'h00;
        for (int k = 0; k < n; k++) begin
            b = tx_q[k];
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ b[j];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic select_dut(input bit s);
        if (s != sel16) begin
            sel16  = s;
            nreset = 1'b0;
            @(posedge clock); #1;
            nreset = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " in_ready"},  in_ready,      0);
        check({tag, " cfg_data"},  cfg_data,      0);
        check({tag, " cfg_shift"}, cfg_shift,     0);
        check({tag, " fab_en"},    fabric_enable, 0);
        check({tag, " busy"},      busy,          0);
        check({tag, " done"},      done,          0);
        check({tag, " error"},     error,         0);
    endtask

    // Runs one load of the data bytes in tx_q. Optional: stall before byte
    // stall_idx, reset after abort_bits shifts, start pulse mid-SHIFT, bad CRC.
    task automatic run_load(input string tag, input int len, input int stall_idx,
                            input int stall_len, input int abort_bits,
                            input bit start_mid, input bit crc_bad,
                            output logic [31:0] act_bits);
        int  k, stall_cnt, nbytes, nexp, bit_err, stall_shift;
        bit  hs, seen_done;
        bit  exp_err;
        nbytes   = (len + 7) / 8;
        nexp     = nbytes;
        exp_err  = 1'b0;
        act_bits = '0;
`ifdef CONFIG_LOADER_CRC_EN
        tx_q.push_back(model_crc(nbytes) ^ (crc_bad ? 8'h01 : 8'h00));
        nexp    = nbytes + 1;
        exp_err = crc_bad;
`endif
        bits_q.delete();
        n_hs = 0; n_done_rise = 0; n_illegal = 0;
        k = 0; stall_cnt = 0; stall_shift = 0; seen_done = 1'b0;

        @(posedge clock); #1;
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        check({tag, " busy after start"}, busy, 1);
        check({tag, " done cleared"},     done, 0);

        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            if (k < tx_q.size() && k == stall_idx && stall_cnt < stall_len) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = (k < tx_q.size()) ? tx_q[k] : 8'($urandom);
            end
            @(negedge clock);
            hs = in_ready && in_valid;
            if (in_ready && !in_valid && k == stall_idx) begin
                stall_cnt++;
                if (cfg_shift) stall_shift++;
            end
            seen_done = done;
            @(posedge clock); #1;
            start = 1'b0;
            if (hs) k++;
            if (abort_bits > 0 && bits_q.size() >= abort_bits) begin
                check({tag, " shifts before reset"}, bits_q.size(), abort_bits);
                nreset   = 1'b0;
                in_valid = 1'b0;
                #1;
                check_all_zero({tag, " async reset"});
                @(posedge clock); #1;
                nreset = 1'b1;
                #1;
                check({tag, " fab_en after reset"}, fabric_enable, 0);
                return;
            end
            if (start_mid && bits_q.size() == 4) begin
                check({tag, " busy mid shift"}, busy, 1);
                start = 1'b1;
            end
        end
        in_valid = 1'b0;

        check({tag, " done seen (timeout)"}, seen_done, 1);
        bit_err = 0;
        for (int i = 0; i < bits_q.size() && i < len; i++) begin
            if (bits_q[i] != model_bit(i)) bit_err++;
            if (i < 32) act_bits[i] = bits_q[i];
        end
        check({tag, " shift count"},     bits_q.size(), len);
        check({tag, " bit errors"},      bit_err,       0);
        check({tag, " bytes accepted"},  n_hs,          nexp);
        check({tag, " done"},            done,          1);
        check({tag, " busy at end"},     busy,          0);
        check({tag, " error"},           error,         exp_err);
        check({tag, " fab_en"},          fabric_enable, !exp_err);
        check({tag, " done pulses"},     n_done_rise,   1);
        check({tag, " illegal combos"},  n_illegal,     0);
        check({tag, " shift in stall"},  stall_shift,   0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          sel16;
        int          len;
        int          nbytes;
        logic [23:0] bytes;      // byte k at [8k +: 8]
        int          stall_idx;
        int          stall_len;
        logic [31:0] exp_bits;   // bit i = i-th cfg_data value
    } vec_t;

    vec_t        vecs[3];
    logic [31:0] act;
    int          len, nb, sidx, slen;
    bit          bad;

    initial begin
        nreset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; sel16 = 1'b0;

        vecs[0] = '{1'b0, 17, 3, 24'h013CA5, -1, 0, 32'h00013CA5};
        vecs[1] = '{1'b0, 17, 3, 24'h013CA5,  1, 5, 32'h00013CA5};
        vecs[2] = '{1'b1, 16, 2, 24'h0000FF, -1, 0, 32'h000000FF};

        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        nreset = 1'b1;

        for (int v = 0; v < 3; v++) begin
            select_dut(vecs[v].sel16);
            tx_q.delete();
            for (int b = 0; b < vecs[v].nbytes; b++) tx_q.push_back(vecs[v].bytes[8*b +: 8]);
            run_load($sformatf("vec%0d", v), vecs[v].len, vecs[v].stall_idx,
                     vecs[v].stall_len, 0, 1'b0, 1'b0, act);
            check($sformatf("vec%0d bit pattern", v), act, vecs[v].exp_bits);
        end

        // Reset after 9 shifts, then a full fresh load.
        select_dut(1'b0);
        tx_q.delete(); tx_q.push_back(8'hA5); tx_q.push_back(8'h3C); tx_q.push_back(8'h01);
        run_load("abort", 17, -1, 0, 9, 1'b0, 1'b0, act);
        tx_q.delete(); tx_q.push_back(8'hA5); tx_q.push_back(8'h3C); tx_q.push_back(8'h01);
        run_load("reload", 17, -1, 0, 0, 1'b0, 1'b0, act);
        check("reload bit pattern", act, 32'h00013CA5);

        // start pulse while shifting is ignored.
        tx_q.delete(); tx_q.push_back(8'hA5); tx_q.push_back(8'h3C); tx_q.push_back(8'h01);
        run_load("start_mid", 17, -1, 0, 0, 1'b1, 1'b0, act);
        check("start_mid bit pattern", act, 32'h00013CA5);

`ifdef CONFIG_LOADER_CRC_EN
        tx_q.delete(); tx_q.push_back(8'hA5); tx_q.push_back(8'h3C); tx_q.push_back(8'h01);
        run_load("crc_bad", 17, -1, 0, 0, 1'b0, 1'b1, act);
`endif

        // Randomised loads against the model.
        for (int r = 0; r < 24; r++) begin
            select_dut(1'($urandom_range(0, 1)));
            len = sel16 ? 16 : 17;
            nb  = (len + 7) / 8;
            tx_q.delete();
            for (int b = 0; b < nb; b++) tx_q.push_back(8'($urandom));
            sidx = $urandom_range(0, nb);
            slen = $urandom_range(0, 6);
            bad  = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            bad  = 1'($urandom_range(0, 1));
`endif
            run_load($sformatf("rand%0d", r), len, sidx, slen, 0, 1'b0, bad, act);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
